// File: rtl/shift_add_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mul_pkg
// Description : Shared types and constants for the shift-add multiplier:
//               FSM state encoding, default operand width and the counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_add_mul_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    localparam int c_DEFAULT_MUL_WIDTH = 4;

    // Iteration counter must hold values up to MUL_WIDTH
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : shift_add_mul_pkg
`default_nettype wire

// File: rtl/shift_add_mul_datapath.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mul_datapath
// Description : Operand registers, accumulator and the add/sub + shift step
//               of the shift-add multiplier. The accumulator's low half
//               starts out holding the multiplier, so its LSB is always the
//               multiplier bit of the current iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul_datapath
    import shift_add_mul_pkg::*;
#(
    parameter int MUL_WIDTH = c_DEFAULT_MUL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic                   i_step,
    input  logic                   i_last,
    input  logic                   i_sign,
    input  logic [MUL_WIDTH-1:0]   i_mcand,
    input  logic [MUL_WIDTH-1:0]   i_mplier,
    output logic [2*MUL_WIDTH-1:0] o_product
);

    logic [MUL_WIDTH-1:0]   r_mcand;
    logic                   r_sign;
    logic [2*MUL_WIDTH-1:0] r_acc;

    logic [MUL_WIDTH-1:0]   w_hi;
    logic [MUL_WIDTH-1:0]   w_lo;
    logic [MUL_WIDTH:0]     w_hi_ext;
    logic [MUL_WIDTH:0]     w_mc_ext;
    logic [MUL_WIDTH:0]     w_sum;
    logic [2*MUL_WIDTH-1:0] w_acc_next;

    // One iteration: conditional add (or subtract for the signed MSB) into
    // the upper half, computed one bit wider so the shift brings in either
    // the unsigned carry or the signed extension bit.
    always_comb begin
        w_hi     = r_acc[2*MUL_WIDTH-1:MUL_WIDTH];
        w_lo     = r_acc[MUL_WIDTH-1:0];
        w_hi_ext = {r_sign & w_hi[MUL_WIDTH-1], w_hi};
        w_mc_ext = {r_sign & r_mcand[MUL_WIDTH-1], r_mcand};
        w_sum    = w_hi_ext;
        if (w_lo[0]) begin
            if (r_sign && i_last) begin
                w_sum = w_hi_ext - w_mc_ext;
            end else begin
                w_sum = w_hi_ext + w_mc_ext;
            end
        end
        w_acc_next = {w_sum, w_lo[MUL_WIDTH-1:1]};
    end

    assign o_product = w_acc_next;

    // Operand capture on an accepted start, accumulator update while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_sign  <= 1'b0;
            r_acc   <= '0;
        end else if (i_load) begin
            r_mcand <= i_mcand;
            r_sign  <= i_sign;
            r_acc   <= {{MUL_WIDTH{1'b0}}, i_mplier};
        end else if (i_step) begin
            r_acc   <= w_acc_next;
        end
    end

endmodule : shift_add_mul_datapath
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential MUL_WIDTH x MUL_WIDTH shift-add multiplier with a
//               start/ready handshake, signed or unsigned per operation.
//               One multiplier bit per clock; result MUL_WIDTH cycles after
//               the accepted start.
//               Optional macro SHIFT_ADD_MUL_DONE_PULSE_EN adds a one-cycle
//               'done' output pulse on each completion.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import shift_add_mul_pkg::*;
#(
    parameter int MUL_WIDTH = c_DEFAULT_MUL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sign,
    input  logic [MUL_WIDTH-1:0]   data_in1,
    input  logic [MUL_WIDTH-1:0]   data_in2,
    output logic [2*MUL_WIDTH-1:0] data_out,
    output logic                   ready
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
    ,
    output logic                   done
`endif
);

    localparam int            CW         = cnt_width(MUL_WIDTH);
    localparam logic [0:0]    c_IDLE     = IDLE;
    localparam logic [0:0]    c_CALC     = CALC;
    localparam logic [CW-1:0] c_LAST_CNT = CW'(MUL_WIDTH - 1);

    logic [0:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   w_load;
    logic                   w_step;
    logic                   w_last;
    logic [2*MUL_WIDTH-1:0] w_product;

    assign w_load = (r_state == c_IDLE) && start;
    assign w_step = (r_state == c_CALC);
    assign w_last = w_step && (r_cnt == c_LAST_CNT);

    shift_add_mul_datapath #(
        .MUL_WIDTH (MUL_WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_last    (w_last),
        .i_sign    (sign),
        .i_mcand   (data_in1),
        .i_mplier  (data_in2),
        .o_product (w_product)
    );

    // Control FSM: accept start only when idle, count iterations, publish
    // the product on the edge that performs the final iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            ready    <= 1'b1;
            data_out <= '0;
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
            done     <= 1'b0;
`endif
        end else begin
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
            done <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_CALC;
                        r_cnt   <= '0;
                        ready   <= 1'b0;
                    end
                end
                c_CALC: begin
                    if (w_last) begin
                        r_state  <= c_IDLE;
                        r_cnt    <= '0;
                        ready    <= 1'b1;
                        data_out <= w_product;
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
                        done     <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule : shift_add_multiplier
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Self-checking bench for shift_add_multiplier (MUL_WIDTH=4):
//               vector table, random operands against a reference product,
//               and hand-written handshake / reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sign;
    logic [W-1:0]   data_in1;
    logic [W-1:0]   data_in2;
    logic [2*W-1:0] data_out;
    logic           ready;
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
    logic           done;
`endif

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] sb_q[$];

    typedef struct {
        logic           s;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    shift_add_multiplier #(
        .MUL_WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_out (data_out),
        .ready    (ready)
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
        ,
        .done     (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Called #1 after the accepting edge with 'already' cycles elapsed;
    // waits for ready to rise, checks latency and pops the scoreboard.
    task automatic wait_done(input int already, input string name);
        int cyc;
        cyc = already;
        while (!ready && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_latency"}, 16'(cyc), 16'(W));
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 16'(0), 16'(1));
        end else begin
            check({name, "_data"}, 16'(data_out), 16'(sb_q.pop_front()));
        end
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
        check({name, "_done_hi"}, 16'(done), 16'(1));
`endif
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
        start    = 1'b1;
        sign     = s;
        data_in1 = a;
        data_in2 = b;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        start    = 1'b0;
        data_in1 = ~a;
        data_in2 = ~b;
        sign     = ~s;
        check({name, "_busy"}, 16'(ready), 16'(0));
        wait_done(0, name);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        data_in1 = '0;
        data_in2 = '0;

        vecs[0] = '{1'b1, 4'h9, 4'hE, 8'h0E};
        vecs[1] = '{1'b0, 4'h9, 4'hE, 8'h7E};
        vecs[2] = '{1'b1, 4'h8, 4'h8, 8'h40};
        vecs[3] = '{1'b1, 4'h7, 4'h8, 8'hC8};
        vecs[4] = '{1'b1, 4'hF, 4'hF, 8'h01};
        vecs[5] = '{1'b1, 4'h0, 4'hB, 8'h00};
        vecs[6] = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vecs[7] = '{1'b0, 4'h0, 4'hF, 8'h00};
        vecs[8] = '{1'b1, 4'h3, 4'hE, 8'hFA};
        vecs[9] = '{1'b0, 4'h5, 4'h3, 8'h0F};

        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_ready", 16'(ready), 16'(1));
        check("reset_data", 16'(data_out), 16'(0));
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
        check("reset_done", 16'(done), 16'(0));
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
`ifdef SHIFT_ADD_MUL_DONE_PULSE_EN
            check($sformatf("vec%0d_done_lo", i), 16'(done), 16'(0));
`endif
        end

        // Random operands against the reference product
        for (int i = 0; i < 8; i++) begin
            logic           s;
            logic [W-1:0]   a;
            logic [W-1:0]   b;
            s = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            run_op(s, a, b, ref_mul(s, a, b), $sformatf("rnd%0d", i));
        end

        // Start pulsed mid-operation is ignored
        start = 1'b1; sign = 1'b1; data_in1 = 4'h9; data_in2 = 4'hE;
        sb_q.push_back(8'h0E);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("midstart_busy", 16'(ready), 16'(0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b1; sign = 1'b0; data_in1 = 4'hF; data_in2 = 4'hF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3, "midstart");
        @(posedge clk);
        #1;
        check("midstart_idle1", 16'(ready), 16'(1));
        @(posedge clk);
        #1;
        check("midstart_idle2", 16'(ready), 16'(1));

        // Start held high: back-to-back operations
        start = 1'b1; sign = 1'b1; data_in1 = 4'h7; data_in2 = 4'h8;
        sb_q.push_back(8'hC8);
        @(posedge clk);
        #1;
        check("held_busy1", 16'(ready), 16'(0));
        sign = 1'b0; data_in1 = 4'hF; data_in2 = 4'hF;
        sb_q.push_back(8'hE1);
        wait_done(0, "held1");
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held_busy2", 16'(ready), 16'(0));
        wait_done(0, "held2");

        // Asynchronous reset mid-operation
        start = 1'b1; sign = 1'b0; data_in1 = 4'h5; data_in2 = 4'h7;
        sb_q.push_back(8'h23);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_ready", 16'(ready), 16'(1));
        check("abort_data", 16'(data_out), 16'(0));
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(1'b1, 4'hA, 4'h3, 8'hEE, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule : tb_shift_add_multiplier
`default_nettype wire
